// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Shares the register file's single write port between the in-order pipeline
// writeback and a long-latency unit that returns results out of order. The
// winning request is registered onto the register-file write interface. A
// per-register pending scoreboard tracks outstanding long-latency results and
// raises a decode stall when a decode operand is still pending.
//
// Build option:
//   WB_STARVE_GUARD_EN - when defined, a starvation counter freezes the
//                        pipeline for one cycle after STARVE_MAX consecutive
//                        blocked long-latency cycles. When undefined, the
//                        pipeline always wins and pipe_hold_o is tied to 0.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   pipe_valid_i/rd_i/data_i      pipeline writeback request
//   lu_valid_i/rd_i/data_i        long-latency result (held until accepted)
//   lu_ready_o                    long-latency result accepted this cycle
//   lu_issue_i, lu_issue_rd_i     long-latency op issued from decode
//   Rs1_id_i, Rs2_id_i            decode-stage source registers
//   stall_o                       combinational decode stall
//   pipe_hold_o                   combinational pipeline freeze
//   RegWrite_o, Rd_o,
//   Wr_reg_data_o                 registered register-file write
//   pend_o                        pending scoreboard (bit 0 always 0)

module wb_port_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pipe_valid_i,
   input  logic [4:0]  pipe_rd_i,
   input  logic [31:0] pipe_data_i,
   input  logic        lu_valid_i,
   output logic        lu_ready_o,
   input  logic [4:0]  lu_rd_i,
   input  logic [31:0] lu_data_i,
   input  logic        lu_issue_i,
   input  logic [4:0]  lu_issue_rd_i,
   input  logic [4:0]  Rs1_id_i,
   input  logic [4:0]  Rs2_id_i,
   output logic        stall_o,
   output logic        pipe_hold_o,
   output logic        RegWrite_o,
   output logic [4:0]  Rd_o,
   output logic [31:0] Wr_reg_data_o,
   output logic [31:0] pend_o
);

   logic        pipe_hold;
   logic        lu_ready;
   logic        pipe_grant;
   logic        lu_grant;
   logic [31:0] pend;
   logic [31:0] pend_nxt;

   if (STARVE_MAX < 1) begin : g_bad_starve_max
      $error("wb_port_arbiter: STARVE_MAX must be >= 1");
   end

`ifdef WB_STARVE_GUARD_EN
   localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] cnt;

   // Once the result has been blocked STARVE_MAX cycles in a row, the
   // pipeline is frozen for one cycle so the long-latency result gets the port.
   assign pipe_hold = (cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (lu_valid_i && !lu_ready) begin
         if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         // Accepted, or nothing waiting: the blocked streak is over.
         cnt <= '0;
      end
   end
`else
   assign pipe_hold = 1'b0;
`endif

   // Pipeline has priority; while held its request is ignored for the cycle.
   assign lu_ready   = !pipe_valid_i || pipe_hold;
   assign pipe_grant = pipe_valid_i && !pipe_hold;
   assign lu_grant   = lu_valid_i && lu_ready;

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWrite_o    <= 1'b0;
         Rd_o          <= 5'd0;
         Wr_reg_data_o <= 32'd0;
      end else begin
         RegWrite_o <= 1'b0;
         if (pipe_grant) begin
            // x0 writes are consumed without enabling the register file.
            RegWrite_o    <= (pipe_rd_i != 5'd0);
            Rd_o          <= pipe_rd_i;
            Wr_reg_data_o <= pipe_data_i;
         end else if (lu_grant) begin
            RegWrite_o    <= (lu_rd_i != 5'd0);
            Rd_o          <= lu_rd_i;
            Wr_reg_data_o <= lu_data_i;
         end
      end
   end

   // NOTE: pend_nxt gets its default before any conditional update so the
   // block stays purely combinational and no latch is inferred.
   always_comb begin
      pend_nxt = pend;
      if (lu_grant) begin
         pend_nxt[lu_rd_i] = 1'b0;
      end
      // Applied after the clear so a same-edge re-issue keeps the bit set.
      if (lu_issue_i) begin
         pend_nxt[lu_issue_rd_i] = 1'b1;
      end
      pend_nxt[0] = 1'b0;
   end

   // NOTE: the scoreboard is a flop array that must be reset; stale pending
   // bits after reset would stall decode forever.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= 32'd0;
      end else begin
         pend <= pend_nxt;
      end
   end

   assign stall_o = ((Rs1_id_i != 5'd0) && pend[Rs1_id_i]) ||
                    ((Rs2_id_i != 5'd0) && pend[Rs2_id_i]) ||
                    pipe_hold;

   assign lu_ready_o  = lu_ready;
   assign pipe_hold_o = pipe_hold;
   assign pend_o      = pend;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a
// randomized run compared against a behavioural model of the write-port
// sharing rules. Builds with or without WB_STARVE_GUARD_EN.
`timescale 1ns/1ps

module tb_wb_port_arbiter;

   localparam int STARVE_MAX = 4;
`ifdef WB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pipe_valid_i = 1'b0;
   logic [4:0]  pipe_rd_i = '0;
   logic [31:0] pipe_data_i = '0;
   logic        lu_valid_i = 1'b0;
   logic        lu_ready_o;
   logic [4:0]  lu_rd_i = '0;
   logic [31:0] lu_data_i = '0;
   logic        lu_issue_i = 1'b0;
   logic [4:0]  lu_issue_rd_i = '0;
   logic [4:0]  Rs1_id_i = '0;
   logic [4:0]  Rs2_id_i = '0;
   logic        stall_o;
   logic        pipe_hold_o;
   logic        RegWrite_o;
   logic [4:0]  Rd_o;
   logic [31:0] Wr_reg_data_o;
   logic [31:0] pend_o;

   int n_checks = 0;
   int n_fail   = 0;

   wb_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_valid_i(pipe_valid_i), .pipe_rd_i(pipe_rd_i), .pipe_data_i(pipe_data_i),
      .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o), .lu_rd_i(lu_rd_i), .lu_data_i(lu_data_i),
      .lu_issue_i(lu_issue_i), .lu_issue_rd_i(lu_issue_rd_i),
      .Rs1_id_i(Rs1_id_i), .Rs2_id_i(Rs2_id_i),
      .stall_o(stall_o), .pipe_hold_o(pipe_hold_o),
      .RegWrite_o(RegWrite_o), .Rd_o(Rd_o), .Wr_reg_data_o(Wr_reg_data_o), .pend_o(pend_o)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   logic        m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   logic [31:0] m_pend;
   int          m_wait;     // consecutive cycles the lu result has been refused
   logic        exp_hold, exp_ready, exp_stall;

   assign exp_hold  = GUARD && (m_wait >= STARVE_MAX);
   assign exp_ready = !pipe_valid_i || exp_hold;
   assign exp_stall = (Rs1_id_i != 0 && m_pend[Rs1_id_i]) ||
                      (Rs2_id_i != 0 && m_pend[Rs2_id_i]) || exp_hold;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_we <= 1'b0; m_rd <= '0; m_data <= '0; m_pend <= '0; m_wait <= 0;
      end else begin
         m_we <= 1'b0;
         if (pipe_valid_i && !exp_hold) begin
            m_we <= (pipe_rd_i != 0); m_rd <= pipe_rd_i; m_data <= pipe_data_i;
         end else if (lu_valid_i) begin
            m_we <= (lu_rd_i != 0); m_rd <= lu_rd_i; m_data <= lu_data_i;
         end
         m_pend <= (m_pend & ~((lu_valid_i && exp_ready) ? (32'd1 << lu_rd_i) : 32'd0))
                   | ((lu_issue_i && lu_issue_rd_i != 0) ? (32'd1 << lu_issue_rd_i) : 32'd0);
         if (lu_valid_i && !exp_ready)
            m_wait <= (m_wait < STARVE_MAX) ? m_wait + 1 : STARVE_MAX;
         else
            m_wait <= 0;
      end
   end

   // Issuing to a still-pending register is illegal unless that same edge
   // retires the old result.
   always @(posedge clk) begin
      if (rst_n && lu_issue_i && lu_issue_rd_i != 0)
         assert (!m_pend[lu_issue_rd_i] || (lu_valid_i && exp_ready && lu_rd_i == lu_issue_rd_i))
            else $error("illegal issue to pending register x%0d", lu_issue_rd_i);
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic do_reset();
      rst_n = 1'b0;
      pipe_valid_i = 0; pipe_rd_i = 0; pipe_data_i = 0;
      lu_valid_i = 0; lu_rd_i = 0; lu_data_i = 0;
      lu_issue_i = 0; lu_issue_rd_i = 0; Rs1_id_i = 0; Rs2_id_i = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_checks++; if (RegWrite_o !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b required 0", RegWrite_o); end
      n_checks++; if (Rd_o !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d required 0", Rd_o); end
      n_checks++; if (Wr_reg_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h required 0", Wr_reg_data_o); end
      do_reset();
      repeat (2) tick();
      n_checks++; if (pend_o !== 32'd0) begin n_fail++; $display("FAIL idle_pend: got %h required 0", pend_o); end
      n_checks++; if (RegWrite_o !== 1'b0) begin n_fail++; $display("FAIL idle_regwrite: got %b required 0", RegWrite_o); end
      n_checks++; if (lu_ready_o !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b required 1", lu_ready_o); end
      n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL idle_stall: got %b required 0", stall_o); end
      n_checks++; if (pipe_hold_o !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got %b required 0", pipe_hold_o); end
   endtask

   task automatic test_issue_commit();
      do_reset();
      Rs1_id_i = 5'd5; lu_issue_i = 1; lu_issue_rd_i = 5'd5;
      #1;
      n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL issue_stall_early: got %b required 0", stall_o); end
      tick();
      lu_issue_i = 0;
      #1;
      n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL issue_stall: got %b required 1", stall_o); end
      n_checks++; if (pend_o !== 32'h0000_0020) begin n_fail++; $display("FAIL issue_pend: got %h required 00000020", pend_o); end
      lu_valid_i = 1; lu_rd_i = 5'd5; lu_data_i = 32'hDEAD_BEEF;
      #1;
      n_checks++; if (lu_ready_o !== 1'b1) begin n_fail++; $display("FAIL commit_ready: got %b required 1", lu_ready_o); end
      tick();
      lu_valid_i = 0;
      #1;
      n_checks++; if (RegWrite_o !== 1'b1) begin n_fail++; $display("FAIL commit_regwrite: got %b required 1", RegWrite_o); end
      n_checks++; if (Rd_o !== 5'd5) begin n_fail++; $display("FAIL commit_rd: got %0d required 5", Rd_o); end
      n_checks++; if (Wr_reg_data_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL commit_data: got %h required deadbeef", Wr_reg_data_o); end
      n_checks++; if (pend_o !== 32'd0) begin n_fail++; $display("FAIL commit_pend: got %h required 0", pend_o); end
      n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL commit_stall: got %b required 0", stall_o); end
      Rs1_id_i = 0;
   endtask

   task automatic test_contention();
      do_reset();
      pipe_valid_i = 1; pipe_rd_i = 5'd3; pipe_data_i = 32'h11;
      lu_valid_i = 1; lu_rd_i = 5'd7; lu_data_i = 32'h22;
      #1;
      n_checks++; if (lu_ready_o !== 1'b0) begin n_fail++; $display("FAIL cont_ready: got %b required 0", lu_ready_o); end
      tick();
      pipe_valid_i = 0;
      n_checks++; if (RegWrite_o !== 1'b1 || Rd_o !== 5'd3 || Wr_reg_data_o !== 32'h11) begin
         n_fail++; $display("FAIL cont_pipe: got we=%b rd=%0d data=%h required we=1 rd=3 data=11", RegWrite_o, Rd_o, Wr_reg_data_o); end
      #1;
      n_checks++; if (lu_ready_o !== 1'b1) begin n_fail++; $display("FAIL cont_ready2: got %b required 1", lu_ready_o); end
      tick();
      lu_valid_i = 0;
      n_checks++; if (RegWrite_o !== 1'b1 || Rd_o !== 5'd7 || Wr_reg_data_o !== 32'h22) begin
         n_fail++; $display("FAIL cont_lu: got we=%b rd=%0d data=%h required we=1 rd=7 data=22", RegWrite_o, Rd_o, Wr_reg_data_o); end
      tick();
      n_checks++; if (RegWrite_o !== 1'b0 || Rd_o !== 5'd7 || Wr_reg_data_o !== 32'h22) begin
         n_fail++; $display("FAIL cont_idle_hold: got we=%b rd=%0d data=%h required we=0 rd=7 data=22", RegWrite_o, Rd_o, Wr_reg_data_o); end
   endtask

   task automatic test_starvation();
      logic exp_h;
      logic exp_we;
      do_reset();
      pipe_valid_i = 1; pipe_rd_i = 5'd4; pipe_data_i = 32'hA5;
      lu_valid_i = 1; lu_rd_i = 5'd8; lu_data_i = 32'h8888_8888;
      for (int k = 1; k <= STARVE_MAX + 3; k++) begin
         #1;
         exp_h = GUARD && (k == STARVE_MAX + 1);
         n_checks++; if (pipe_hold_o !== exp_h) begin n_fail++; $display("FAIL starve_hold[%0d]: got %b required %b", k, pipe_hold_o, exp_h); end
         n_checks++; if (lu_ready_o !== exp_h) begin n_fail++; $display("FAIL starve_ready[%0d]: got %b required %b", k, lu_ready_o, exp_h); end
         n_checks++; if (stall_o !== exp_h) begin n_fail++; $display("FAIL starve_stall[%0d]: got %b required %b", k, stall_o, exp_h); end
         tick();
         if (exp_h) begin
            lu_valid_i = 0;
            n_checks++; if (RegWrite_o !== 1'b1 || Rd_o !== 5'd8 || Wr_reg_data_o !== 32'h8888_8888) begin
               n_fail++; $display("FAIL starve_lu[%0d]: got we=%b rd=%0d data=%h required we=1 rd=8 data=88888888", k, RegWrite_o, Rd_o, Wr_reg_data_o); end
         end else begin
            n_checks++; if (RegWrite_o !== 1'b1 || Rd_o !== 5'd4 || Wr_reg_data_o !== 32'hA5) begin
               n_fail++; $display("FAIL starve_pipe[%0d]: got we=%b rd=%0d data=%h required we=1 rd=4 data=a5", k, RegWrite_o, Rd_o, Wr_reg_data_o); end
         end
      end
      // Drop the pipeline: any still-waiting lu result must commit now.
      pipe_valid_i = 0;
      exp_we = lu_valid_i;
      tick();
      lu_valid_i = 0;
      n_checks++; if (RegWrite_o !== exp_we) begin n_fail++; $display("FAIL starve_drain: got %b required %b", RegWrite_o, exp_we); end
      if (exp_we) begin
         n_checks++; if (Rd_o !== 5'd8) begin n_fail++; $display("FAIL starve_drain_rd: got %0d required 8", Rd_o); end
      end
   endtask

   task automatic test_rd_zero();
      do_reset();
      pipe_valid_i = 1; pipe_rd_i = 5'd0; pipe_data_i = 32'h1234;
      tick();
      pipe_valid_i = 0;
      n_checks++; if (RegWrite_o !== 1'b0) begin n_fail++; $display("FAIL rd0_pipe: got %b required 0", RegWrite_o); end
      lu_valid_i = 1; lu_rd_i = 5'd0; lu_data_i = 32'h5678;
      tick();
      lu_valid_i = 0;
      n_checks++; if (RegWrite_o !== 1'b0) begin n_fail++; $display("FAIL rd0_lu: got %b required 0", RegWrite_o); end
      lu_issue_i = 1; lu_issue_rd_i = 5'd2;
      tick();
      lu_issue_rd_i = 5'd0;
      tick();
      lu_issue_i = 0;
      n_checks++; if (pend_o !== 32'h0000_0004) begin n_fail++; $display("FAIL rd0_issue: got %h required 00000004", pend_o); end
   endtask

   task automatic test_set_wins();
      do_reset();
      lu_issue_i = 1; lu_issue_rd_i = 5'd9;
      tick();
      lu_valid_i = 1; lu_rd_i = 5'd9; lu_data_i = 32'h99;
      tick();
      lu_issue_i = 0; lu_valid_i = 0;
      n_checks++; if (pend_o !== 32'h0000_0200) begin n_fail++; $display("FAIL setwins_pend: got %h required 00000200", pend_o); end
      n_checks++; if (RegWrite_o !== 1'b1 || Rd_o !== 5'd9) begin n_fail++; $display("FAIL setwins_commit: got we=%b rd=%0d required we=1 rd=9", RegWrite_o, Rd_o); end
   endtask

   task automatic test_async_reset();
      do_reset();
      lu_issue_i = 1; lu_issue_rd_i = 5'd3;
      tick();
      lu_issue_rd_i = 5'd12;
      pipe_valid_i = 1; pipe_rd_i = 5'd6; pipe_data_i = 32'h66;
      tick();
      lu_issue_i = 0; pipe_valid_i = 0;
      n_checks++; if (pend_o !== 32'h0000_1008) begin n_fail++; $display("FAIL arst_pre_pend: got %h required 00001008", pend_o); end
      n_checks++; if (RegWrite_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre_we: got %b required 1", RegWrite_o); end
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (pend_o !== 32'd0) begin n_fail++; $display("FAIL arst_pend: got %h required 0", pend_o); end
      n_checks++; if (RegWrite_o !== 1'b0 || Rd_o !== 5'd0 || Wr_reg_data_o !== 32'd0) begin
         n_fail++; $display("FAIL arst_out: got we=%b rd=%0d data=%h required all 0", RegWrite_o, Rd_o, Wr_reg_data_o); end
      do_reset();
   endtask

   task automatic test_random();
      bit busy [32];
      bit acc, held;
      int r;
      do_reset();
      held = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         // Long-latency unit returns an outstanding result, or rarely an x0 one.
         if (!lu_valid_i) begin
            r = $urandom_range(1, 31);
            if ($urandom_range(0, 2) == 0 && busy[r]) begin
               lu_valid_i = 1; lu_rd_i = 5'(r); lu_data_i = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
               lu_valid_i = 1; lu_rd_i = 5'd0; lu_data_i = $urandom;
            end
         end
         lu_issue_i = 0;
         r = $urandom_range(0, 31);
         lu_issue_rd_i = 5'(r);
         if ($urandom_range(0, 3) == 0 && (r == 0 || !busy[r])) begin
            lu_issue_i = 1;
            if (r != 0) busy[r] = 1;
         end
         if (!held) begin
            pipe_valid_i = ($urandom_range(0, 9) < 6);
            pipe_rd_i = 5'($urandom_range(0, 31));
            pipe_data_i = $urandom;
         end
         Rs1_id_i = 5'($urandom_range(0, 31));
         Rs2_id_i = 5'($urandom_range(0, 31));
         #1;
         n_checks++; if (stall_o !== exp_stall) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %b required %b", cyc, stall_o, exp_stall); end
         n_checks++; if (lu_ready_o !== exp_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b required %b", cyc, lu_ready_o, exp_ready); end
         n_checks++; if (pipe_hold_o !== exp_hold) begin n_fail++; $display("FAIL rnd_hold[%0d]: got %b required %b", cyc, pipe_hold_o, exp_hold); end
         acc  = lu_valid_i && exp_ready;
         held = exp_hold;
         tick();
         n_checks++; if (RegWrite_o !== m_we || Rd_o !== m_rd || Wr_reg_data_o !== m_data) begin
            n_fail++; $display("FAIL rnd_write[%0d]: got we=%b rd=%0d data=%h required we=%b rd=%0d data=%h",
                               cyc, RegWrite_o, Rd_o, Wr_reg_data_o, m_we, m_rd, m_data); end
         n_checks++; if (pend_o !== m_pend) begin n_fail++; $display("FAIL rnd_pend[%0d]: got %h required %h", cyc, pend_o, m_pend); end
         if (acc) begin
            busy[lu_rd_i] = 0;
            lu_valid_i = 0;
         end
      end
      pipe_valid_i = 0; lu_valid_i = 0; lu_issue_i = 0;
   endtask

   initial begin
      test_reset();
      test_issue_commit();
      test_contention();
      test_starvation();
      test_rd_zero();
      test_set_wins();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
